sw_debounce_sync: RTL and testbench

- Upstream conditioning stage for the 2-switch state-machine top.
- Synchronises raw asynchronous slide-switch/button inputs into the `clk` domain and debounces each one independently.
- Produces clean levels that drive the FSM's `sw` inputs directly, plus optional one-cycle rise/fall strobes for edge-triggered FSM variants.

---
 rtl/sw_debounce_sync_pkg.sv | 23 ++
 rtl/sw_debounce_sync_channel.sv | 61 ++++++
 rtl/sw_debounce_sync.sv | 33 +++
 tb/tb_sw_debounce_sync.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_sync_pkg.sv
// Shared constants for the switch synchroniser / debouncer.
// Default debounce window is derived from the system clock rate.
package sw_debounce_sync_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEF =
    (CLK_HZ / 1000) * DEBOUNCE_MS;

  // Bits needed to hold values 0 .. v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sw_debounce_sync_channel.sv
// One switch channel: 2-flop synchroniser, stability counter, level.
// Edge strobes exist only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce_channel
  import sw_debounce_sync_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (s2 != clean) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & s2;
      fall <= accept & ~s2;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_sync.sv
// N_SW independent debounced switch channels for the FSM sw inputs.
// Rise/fall strobes are live only with SW_DEBOUNCE_EDGE_EN defined.
module sw_debounce_sync
  import sw_debounce_sync_pkg::*;
#(
  parameter int unsigned N_SW = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_clean,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
);

  localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    sw_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (sw_raw[i]),
      .clean(sw_clean[i]),
      .rise (sw_rise[i]),
      .fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync with N_SW=2, DEBOUNCE_CYCLES=4.
// Hand tables, corner sequences and random traffic against a model.
module tb_sw_debounce_sync;

  localparam int N = 2;
  localparam int D = 4;

`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct {
    bit         rst_n;
    logic [1:0] raw;
    logic [1:0] clean;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw_raw = 2'b00;
  logic [1:0] sw_clean;
  logic [1:0] sw_rise;
  logic [1:0] sw_fall;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_clean;
  logic [1:0] m_rise;
  logic [1:0] m_fall;
  int         run [N];
  logic [1:0] samp [$];
  vec_t       tbl [$];

  always #5 clk = ~clk;

  sw_debounce_sync #(
    .N_SW           (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  task automatic chk(input string nm, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int i = 0; i < N; i++) run[i] = 0;
    samp.delete();
    samp.push_back(2'b00);
    samp.push_back(2'b00);
  endfunction

  // A level is accepted once the synchronised input has disagreed
  // with it for D consecutive edges; the sync path delays by 2 edges.
  function automatic void model_edge(input logic [1:0] raw);
    logic [1:0] v;
    v = samp[samp.size() - 2];
    samp.push_back(raw);
    if (samp.size() > 3) void'(samp.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i] != m_clean[i]) begin
        run[i]++;
        if (run[i] == D) begin
          m_clean[i] = v[i];
          m_rise[i]  = EDGE & v[i];
          m_fall[i]  = EDGE & ~v[i];
          run[i]     = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    if (!reset) model_reset();
    else model_edge(sw_raw);
    #1;
    chk("model_clean", sw_clean, m_clean);
    chk("model_rise", sw_rise, m_rise);
    chk("model_fall", sw_fall, m_fall);
    chk("rise_fall_excl", sw_rise & sw_fall, 2'b00);
  endtask

  task automatic add(input bit r, input logic [1:0] raw,
                     input logic [1:0] cl, input logic [1:0] ri,
                     input logic [1:0] fa, input int n);
    vec_t v;
    v.rst_n = r;
    v.raw   = raw;
    v.clean = cl;
    v.rise  = ri;
    v.fall  = fa;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    int lat;
    int nrise;
    logic [1:0] emask;
    logic [11:0] bpat;
    emask = EDGE ? 2'b11 : 2'b00;
    model_reset();

    sw_raw = 2'b11;
    #1 reset = 1'b0;
    #1;
    chk("async_reset_clean", sw_clean, 2'b00);
    chk("async_reset_rise", sw_rise, 2'b00);
    chk("async_reset_fall", sw_fall, 2'b00);

    add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2);
    add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1);
    add(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2);
    add(1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 5);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 1);
    add(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    add(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 5);
    add(1'b1, 2'b01, 2'b01, 2'b01, 2'b00, 1);
    add(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 2);
    add(1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 3);
    add(1'b1, 2'b01, 2'b01, 2'b00, 2'b00, 8);

    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst_n;
      sw_raw = tbl[i].raw;
      step();
      chk($sformatf("tbl%0d_clean", i), sw_clean, tbl[i].clean);
      chk($sformatf("tbl%0d_rise", i), sw_rise, tbl[i].rise & emask);
      chk($sformatf("tbl%0d_fall", i), sw_fall, tbl[i].fall & emask);
    end

    // Bounce on channel 0: 3-cycle runs never reach D, then hold high.
    sw_raw = 2'b00;
    repeat (10) step();
    bpat  = 12'b000111000111;
    nrise = 0;
    for (int i = 0; i < 12; i++) begin
      sw_raw = {1'b0, bpat[i]};
      step();
      nrise += int'(sw_rise[0]);
    end
    chk("bounce_no_accept", sw_clean, 2'b00);
    sw_raw = 2'b01;
    repeat (10) begin
      step();
      nrise += int'(sw_rise[0]);
    end
    chk("bounce_final", sw_clean, 2'b01);
    chk_int("bounce_rise_count", nrise, EDGE ? 1 : 0);

    // Reset after two mismatch cycles, then full latency from release.
    sw_raw = 2'b11;
    repeat (10) step();
    chk("mid_pre", sw_clean, 2'b11);
    sw_raw = 2'b00;
    repeat (4) step();
    chk("mid_hold", sw_clean, 2'b11);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_clean", sw_clean, 2'b00);
    chk("mid_async_fall", sw_fall, 2'b00);
    model_reset();
    repeat (2) step();
    reset  = 1'b1;
    sw_raw = 2'b11;
    lat    = 0;
    do begin
      step();
      lat++;
    end while (sw_clean != 2'b11 && lat < 20);
    chk_int("release_latency", lat, 6);
    chk("release_rise", sw_rise, emask);
    #1 reset = 1'b0;
    #1;
    chk("pulse_cancel_rise", sw_rise, 2'b00);
    chk("pulse_cancel_clean", sw_clean, 2'b00);
    model_reset();
    step();
    reset = 1'b1;

    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(5) == 0) sw_raw[b] = ~sw_raw[b];
      reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
